// File: rtl/dvs_pkg.sv
// Shared types and constants for the DVS packet decoder.
// DVS_CHECKSUM_EN adds the trailing checksum byte and its state.
package dvs_pkg;

  localparam int unsigned DVS_COORD_W = 7;
  localparam int unsigned CNT_W       = 8;

`ifdef DVS_CHECKSUM_EN
  typedef enum logic [2:0] {StSync, StX, StY, StFlags, StCsum} dvs_state_e;
`else
  typedef enum logic [1:0] {StSync, StX, StY, StFlags} dvs_state_e;
`endif

  typedef struct packed {
    logic [DVS_COORD_W-1:0] x;
    logic [DVS_COORD_W-1:0] y;
    logic                   pol;
  } dvs_event_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dvs_packet_decoder.sv
// Decodes UART byte packets (SYNC, X, Y, FLAGS[, CSUM]) into a ready/valid DVS event stream.
// Define DVS_CHECKSUM_EN to enable the 5-byte packet with XOR checksum.
module dvs_packet_decoder
  import dvs_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = 8'hAA,
  parameter int unsigned TIMEOUT_CLKS = 20000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [DVS_COORD_W-1:0] ev_x,
  output logic [DVS_COORD_W-1:0] ev_y,
  output logic                   ev_pol,
  output logic [CNT_W-1:0]       csum_err_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [CNT_W-1:0]       frame_err_cnt,
  output logic                   busy
);

  localparam int unsigned     GapW    = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [GapW-1:0] GapLast = GapW'(TIMEOUT_CLKS - 1);

  dvs_state_e      state_q, state_d;
  dvs_event_t      pkt_q, pkt_d;
  dvs_event_t      ev_q, ev_d;
  logic            ev_valid_q, ev_valid_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            complete, frame_inc, csum_inc, drop_inc;
`ifdef DVS_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    gap_d     = gap_q;
    complete  = 1'b0;
    frame_inc = 1'b0;
    csum_inc  = 1'b0;
`ifdef DVS_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    if (rx_valid) begin
      gap_d = '0;
      unique case (state_q)
        StSync: if (rx_data == SYNC_BYTE) state_d = StX;
        StX: begin
          if (rx_data[7]) begin
            frame_inc = 1'b1;
            state_d   = StSync;
          end else begin
            pkt_d.x = rx_data[6:0];
            state_d = StY;
          end
`ifdef DVS_CHECKSUM_EN
          csum_d = rx_data;
`endif
        end
        StY: begin
          if (rx_data[7]) begin
            frame_inc = 1'b1;
            state_d   = StSync;
          end else begin
            pkt_d.y = rx_data[6:0];
            state_d = StFlags;
          end
`ifdef DVS_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
        end
        StFlags: begin
          pkt_d.pol = rx_data[0];
`ifdef DVS_CHECKSUM_EN
          csum_d  = csum_q ^ rx_data;
          state_d = StCsum;
`else
          complete = 1'b1;
          state_d  = StSync;
`endif
        end
`ifdef DVS_CHECKSUM_EN
        StCsum: begin
          if (rx_data == csum_q) complete = 1'b1;
          else                   csum_inc = 1'b1;
          state_d = StSync;
        end
`endif
      endcase
    end else if (state_q != StSync) begin
      // A byte arriving on the expiry cycle takes priority over the timeout.
      if (gap_q == GapLast) begin
        frame_inc = 1'b1;
        state_d   = StSync;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
    if (state_d == StSync) gap_d = '0;
  end

  always_comb begin
    ev_d       = ev_q;
    ev_valid_d = ev_valid_q;
    drop_inc   = 1'b0;
    if (ev_valid_q && ev_ready) ev_valid_d = 1'b0;
    if (complete) begin
      if (!ev_valid_q || ev_ready) begin
        ev_d       = pkt_d;
        ev_valid_d = 1'b1;
      end else begin
        drop_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StSync;
      pkt_q      <= '0;
      ev_q       <= '0;
      ev_valid_q <= 1'b0;
      gap_q      <= '0;
`ifdef DVS_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      ev_q       <= ev_d;
      ev_valid_q <= ev_valid_d;
      gap_q      <= gap_d;
`ifdef DVS_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  sat_counter #(.Width(CNT_W)) u_csum_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (csum_inc),
    .count_o (csum_err_cnt)
  );

  sat_counter #(.Width(CNT_W)) u_drop_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (drop_inc),
    .count_o (drop_cnt)
  );

  sat_counter #(.Width(CNT_W)) u_frame_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (frame_inc),
    .count_o (frame_err_cnt)
  );

  assign ev_valid = ev_valid_q;
  assign ev_x     = ev_q.x;
  assign ev_y     = ev_q.y;
  assign ev_pol   = ev_q.pol;
  assign busy     = (state_q != StSync);

endmodule

// File: tb/tb_dvs_packet_decoder.sv
// Directed table-driven bench for dvs_packet_decoder; adapts to DVS_CHECKSUM_EN.
module tb_dvs_packet_decoder;

  localparam int unsigned Tmo = 16;
`ifdef DVS_CHECKSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif
  localparam int PktLen = CsumEn ? 5 : 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       ev_valid, ev_ready, ev_pol, busy;
  logic [6:0] ev_x, ev_y;
  logic [7:0] csum_err_cnt, drop_cnt, frame_err_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_frame = 0;
  int exp_csum = 0;
  int exp_drop = 0;

  always #5 clk = ~clk;

  dvs_packet_decoder #(.SYNC_BYTE(8'hAA), .TIMEOUT_CLKS(Tmo)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_x          (ev_x),
    .ev_y          (ev_y),
    .ev_pol        (ev_pol),
    .csum_err_cnt  (csum_err_cnt),
    .drop_cnt      (drop_cnt),
    .frame_err_cnt (frame_err_cnt),
    .busy          (busy)
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] f;
    bit         corrupt;
    bit         exp_ev;
    logic [6:0] ex;
    logic [6:0] ey;
    bit         ep;
    int         d_frame;
    int         d_csum;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, " frame_err_cnt"}, 32'(frame_err_cnt), 32'(exp_frame));
    chk({tag, " csum_err_cnt"}, 32'(csum_err_cnt), 32'(exp_csum));
    chk({tag, " drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
  endtask

  task automatic chk_ev(input string tag, input logic [6:0] x, input logic [6:0] y, input bit p);
    chk({tag, " ev_valid"}, 32'(ev_valid), 32'd1);
    chk({tag, " ev_x"}, 32'(ev_x), 32'(x));
    chk({tag, " ev_y"}, 32'(ev_y), 32'(y));
    chk({tag, " ev_pol"}, 32'(ev_pol), 32'(p));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_part(input logic [7:0] x, input logic [7:0] y, input logic [7:0] f,
                           input bit corrupt, input int from, input int upto);
    logic [7:0] b[5];
    b[0] = 8'hAA;
    b[1] = x;
    b[2] = y;
    b[3] = f;
    b[4] = (x ^ y ^ f) ^ (corrupt ? 8'hFF : 8'h00);
    for (int i = from; i <= upto && i < PktLen; i++) send_byte(b[i]);
  endtask

  task automatic send_pkt(input logic [7:0] x, input logic [7:0] y, input logic [7:0] f,
                          input bit corrupt);
    send_part(x, y, f, corrupt, 0, PktLen - 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h12, 8'h34, 8'h01, 0, 1, 7'h12, 7'h34, 1, 0, 0};
    vecs[1] = '{8'h12, 8'h34, 8'h01, 1, !CsumEn, 7'h12, 7'h34, 1, 0, CsumEn ? 1 : 0};
    vecs[2] = '{8'h7F, 8'h00, 8'hFE, 0, 1, 7'h7F, 7'h00, 0, 0, 0};
    vecs[3] = '{8'h00, 8'h7F, 8'hFF, 0, 1, 7'h00, 7'h7F, 1, 0, 0};
    vecs[4] = '{8'h85, 8'h34, 8'h01, 0, 0, 7'h00, 7'h00, 0, 1, 0};
    vecs[5] = '{8'h12, 8'h80, 8'h01, 0, 0, 7'h00, 7'h00, 0, 1, 0};
    vecs[6] = '{8'h55, 8'h2A, 8'h00, 0, 1, 7'h55, 7'h2A, 0, 0, 0};
    vecs[7] = '{8'h01, 8'h02, 8'h03, 0, 1, 7'h01, 7'h02, 1, 0, 0};

    ev_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset ev_valid", 32'(ev_valid), 32'd0);
    chk("reset ev_x", 32'(ev_x), 32'd0);
    chk("reset ev_y", 32'(ev_y), 32'd0);
    chk("reset ev_pol", 32'(ev_pol), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk_cnts("reset");
    rst = 1'b0;

    // Junk before sync is ignored; a bad X byte aborts the frame.
    send_byte(8'h00);
    send_byte(8'h55);
    chk("junk busy", 32'(busy), 32'd0);
    chk_cnts("junk");
    send_byte(8'hAA);
    chk("sync busy", 32'(busy), 32'd1);
    send_byte(8'h85);
    exp_frame++;
    chk("bad x busy", 32'(busy), 32'd0);
    chk_cnts("bad x");

    for (int i = 0; i < 8; i++) begin
      send_pkt(vecs[i].x, vecs[i].y, vecs[i].f, vecs[i].corrupt);
      exp_frame += vecs[i].d_frame;
      exp_csum  += vecs[i].d_csum;
      if (vecs[i].exp_ev) chk_ev($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ep);
      else chk($sformatf("vec%0d ev_valid", i), 32'(ev_valid), 32'd0);
      @(negedge clk);
      chk($sformatf("vec%0d ev_valid clear", i), 32'(ev_valid), 32'd0);
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
      chk_cnts($sformatf("vec%0d", i));
    end

    // Byte landing exactly on the expiry cycle is still accepted.
    send_part(8'h12, 8'h34, 8'h00, 0, 0, 1);
    repeat (Tmo - 2) @(negedge clk);
    chk("gap T-2 busy", 32'(busy), 32'd1);
    chk_cnts("gap T-2");
    @(negedge clk);
    send_part(8'h12, 8'h34, 8'h00, 0, 2, PktLen - 1);
    chk_ev("gap T-1", 7'h12, 7'h34, 1'b0);
    @(negedge clk);
    send_part(8'h12, 8'h34, 8'h00, 0, 0, 1);
    repeat (Tmo) @(negedge clk);
    exp_frame++;
    chk("timeout busy", 32'(busy), 32'd0);
    chk_cnts("timeout");

    // Backpressure: hold first event, drop second, accept third on ready rise.
    ev_ready = 1'b0;
    send_pkt(8'h11, 8'h22, 8'h01, 0);
    chk_ev("bp first", 7'h11, 7'h22, 1'b1);
    repeat (3) @(negedge clk);
    chk_ev("bp hold", 7'h11, 7'h22, 1'b1);
    send_pkt(8'h33, 8'h44, 8'h00, 0);
    exp_drop++;
    chk_ev("bp drop", 7'h11, 7'h22, 1'b1);
    chk_cnts("bp drop");
    send_part(8'h55, 8'h66, 8'h01, 0, 0, PktLen - 2);
    ev_ready = 1'b1;
    send_part(8'h55, 8'h66, 8'h01, 0, PktLen - 1, PktLen - 1);
    chk_ev("bp replace", 7'h55, 7'h66, 1'b1);
    chk_cnts("bp replace");
    @(negedge clk);
    chk("bp clear", 32'(ev_valid), 32'd0);

    for (int i = 0; i < 300; i++) begin
      send_byte(8'hAA);
      send_byte(8'h85);
    end
    exp_frame = 255;
    chk_cnts("frame sat");
    if (CsumEn) begin
      for (int i = 0; i < 300; i++) send_pkt(8'h12, 8'h34, 8'h01, 1);
      exp_csum = 255;
      chk_cnts("csum sat");
    end

    // Reset with a pending event and a partial packet in flight.
    ev_ready = 1'b0;
    send_pkt(8'h0A, 8'h0B, 8'h01, 0);
    chk_ev("pre-reset", 7'h0A, 7'h0B, 1'b1);
    send_part(8'h12, 8'h34, 8'h01, 0, 0, 1);
    rst = 1'b1;
    @(negedge clk);
    exp_frame = 0;
    exp_csum  = 0;
    exp_drop  = 0;
    chk("rst ev_valid", 32'(ev_valid), 32'd0);
    chk("rst ev_x", 32'(ev_x), 32'd0);
    chk("rst ev_y", 32'(ev_y), 32'd0);
    chk("rst ev_pol", 32'(ev_pol), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk_cnts("rst");
    rst = 1'b0;
    ev_ready = 1'b1;
    send_byte(8'hAA);
    chk("post-rst sync busy", 32'(busy), 32'd1);
    send_part(8'h21, 8'h43, 8'h01, 0, 1, PktLen - 1);
    chk_ev("post-rst pkt", 7'h21, 7'h43, 1'b1);
    chk_cnts("post-rst pkt");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
